// File: rtl/pipe_pkg.sv
// Purpose : shared types and encodings for the hazard/forwarding unit.
// Latency : n/a (package only).
// Backpressure: n/a.
package pipe_pkg;

    // Register-address width of the datapath.
    localparam int REG_AW = 5;

    // ALU operand select encodings (2'b11 is never produced).
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    // Hazard-relevant fields carried alongside each pipeline stage.
    typedef struct packed {
        logic              RegWrite;
        logic              MemRead;
        logic [REG_AW-1:0] WriteReg;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } hz_fields_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Purpose : decode-side inputs and pipeline-control / forward-select outputs of the hazard unit.
// Latency : n/a (signal bundle).
// Backpressure: none; stall is expressed through PCWrite / IF_ID_Write.
// Ports   : master = decode/datapath side, slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [REG_AW-1:0] ID_rs;
    logic [REG_AW-1:0] ID_rt;
    logic              ID_UseRs;
    logic              ID_UseRt;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic [REG_AW-1:0] ID_WriteReg;
    logic              EX_BranchTaken;

    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic              IF_ID_Flush;
    logic              ID_EX_Bubble;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemRead,
               ID_WriteReg, EX_BranchTaken,
        input  ForwardA, ForwardB, PCWrite, IF_ID_Write, IF_ID_Flush,
               ID_EX_Bubble, StallCount
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemRead,
               ID_WriteReg, EX_BranchTaken,
        output ForwardA, ForwardB, PCWrite, IF_ID_Write, IF_ID_Flush,
               ID_EX_Bubble, StallCount
    );

endinterface

// File: rtl/fwd_select.sv
// Purpose : picks the operand source for one EX-stage ALU input (MEM beats WB, $0 never forwarded).
// Latency : combinational.
// Backpressure: none.
// Ports   : src = EX source register; mem_*/wb_* = producer fields of S_MEM/S_WB; fwd = select code.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_write_reg,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic [1:0]        fwd
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_write_reg != ZERO_REG) && (mem_write_reg == src);
    assign wb_hit  = wb_reg_write  && (wb_write_reg  != ZERO_REG) && (wb_write_reg  == src);

    always_comb begin
        fwd = FWD_REGFILE;
        if (mem_hit) begin
            fwd = FWD_MEM;
        end else if (wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Purpose : forward selects, load-use stall and branch flush from shadow EX/MEM/WB hazard fields.
// Latency : all controls combinational; shadows advance every CLK edge in lockstep with the datapath.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and bubbles ID/EX.
// Ports   : CLK, Reset (sync, active-high), bus (slave modport: ID fields in, controls out).
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    hazard_forward_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_fields_t       s_ex_q,  s_ex_d;
    hz_fields_t       s_mem_q, s_mem_d;
    hz_fields_t       s_wb_q,  s_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic branch;
    logic stall;
    logic bubble;

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use = s_ex_q.MemRead && (s_ex_q.WriteReg != ZERO_REG) &&
                      ((bus.ID_UseRs && (bus.ID_rs == s_ex_q.WriteReg)) ||
                       (bus.ID_UseRt && (bus.ID_rt == s_ex_q.WriteReg)));

    assign branch = bus.EX_BranchTaken;
    // A taken branch squashes the stalled instruction, so it overrides the stall.
    assign stall  = load_use && !branch;
    assign bubble = load_use || branch;

    always_comb begin
        bus.PCWrite      = !stall;
        bus.IF_ID_Write  = !stall;
        bus.IF_ID_Flush  = branch;
        bus.ID_EX_Bubble = bubble;
        bus.StallCount   = stall_cnt_q;
    end

    always_comb begin
        s_ex_d = '0;
        if (!bubble) begin
            s_ex_d.RegWrite = bus.ID_RegWrite;
            s_ex_d.MemRead  = bus.ID_MemRead;
            s_ex_d.WriteReg = bus.ID_WriteReg;
            s_ex_d.rs       = bus.ID_rs;
            s_ex_d.rt       = bus.ID_rt;
        end
        s_mem_d = s_ex_q;
        s_wb_d  = s_mem_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s_ex_q      <= '0;
            s_mem_q     <= '0;
            s_wb_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            s_ex_q      <= s_ex_d;
            s_mem_q     <= s_mem_d;
            s_wb_q      <= s_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src           (s_ex_q.rs),
        .mem_reg_write (s_mem_q.RegWrite),
        .mem_write_reg (s_mem_q.WriteReg),
        .wb_reg_write  (s_wb_q.RegWrite),
        .wb_write_reg  (s_wb_q.WriteReg),
        .fwd           (bus.ForwardA)
    );

    fwd_select u_fwd_b (
        .src           (s_ex_q.rt),
        .mem_reg_write (s_mem_q.RegWrite),
        .mem_write_reg (s_mem_q.WriteReg),
        .wb_reg_write  (s_wb_q.RegWrite),
        .wb_write_reg  (s_wb_q.WriteReg),
        .fwd           (bus.ForwardB)
    );

    // WB-stage load flag and source registers are kept for pipeline fidelity but not consumed.
    logic unused_wb_fields;
    assign unused_wb_fields = ^{s_wb_q.MemRead, s_wb_q.rs, s_wb_q.rt};

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int TB_CNT_W = 8;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    hazard_forward_unit_if #(.CNT_W(TB_CNT_W)) bus ();

    hazard_forward_unit #(.CNT_W(TB_CNT_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decoded instruction in ID.
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rs, input logic use_rt,
                          input logic reg_write, input logic mem_read,
                          input logic [4:0] wr);
        bus.ID_rs       = rs;
        bus.ID_rt       = rt;
        bus.ID_UseRs    = use_rs;
        bus.ID_UseRt    = use_rt;
        bus.ID_RegWrite = reg_write;
        bus.ID_MemRead  = mem_read;
        bus.ID_WriteReg = wr;
    endtask

    task automatic set_nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        set_nop();
        repeat (3) tick();
    endtask

    task automatic chk_ctrl(input string tag, input logic pcw, input logic ifw,
                            input logic flush, input logic bub);
        chk({tag, "_pcwrite"}, {31'd0, bus.PCWrite},      {31'd0, pcw});
        chk({tag, "_ifidwr"},  {31'd0, bus.IF_ID_Write},  {31'd0, ifw});
        chk({tag, "_flush"},   {31'd0, bus.IF_ID_Flush},  {31'd0, flush});
        chk({tag, "_bubble"},  {31'd0, bus.ID_EX_Bubble}, {31'd0, bub});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        bus.EX_BranchTaken = 1'b0;
        set_nop();
        repeat (2) tick();
        Reset = 1'b0;
        settle();

        // Reset state
        chk("rst_fwda", {30'd0, bus.ForwardA}, 32'd0);
        chk("rst_fwdb", {30'd0, bus.ForwardB}, 32'd0);
        chk_ctrl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_cnt", {24'd0, bus.StallCount}, 32'd0);

        // add $3,$1,$2 ; add $4,$3,$5 -> MEM forward on A
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        settle();
        chk("raw_nostall", {31'd0, bus.PCWrite}, 32'd1);
        tick();
        set_nop();
        settle();
        chk("mem_fwda", {30'd0, bus.ForwardA}, 32'd2);
        chk("mem_fwdb", {30'd0, bus.ForwardB}, 32'd0);
        drain();

        // add $3 ; nop ; sub $6,$7,$3 -> WB forward on B
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        set_nop();
        tick();
        set_id(5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        set_nop();
        settle();
        chk("wb_fwdb", {30'd0, bus.ForwardB}, 32'd1);
        chk("wb_fwda", {30'd0, bus.ForwardA}, 32'd0);
        drain();

        // add $3 ; add $3 ; sub $6,$7,$3 -> MEM wins over WB
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        set_id(5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        set_nop();
        settle();
        chk("prio_fwdb", {30'd0, bus.ForwardB}, 32'd2);
        drain();

        // lw $2,0($1) ; add $4,$2,$2 -> one stall then WB forward on both
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        settle();
        chk_ctrl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_cnt0", {24'd0, bus.StallCount}, 32'd0);
        tick();
        settle();
        chk_ctrl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_cnt1", {24'd0, bus.StallCount}, 32'd1);
        tick();
        set_nop();
        settle();
        chk("lu_fwda", {30'd0, bus.ForwardA}, 32'd1);
        chk("lu_fwdb", {30'd0, bus.ForwardB}, 32'd1);
        drain();

        // add $0 ; reader of $0 -> no forward; lw $0 -> no stall
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        tick();
        set_nop();
        settle();
        chk("r0_fwda", {30'd0, bus.ForwardA}, 32'd0);
        chk("r0_fwdb", {30'd0, bus.ForwardB}, 32'd0);
        drain();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        settle();
        chk_ctrl("r0_lw", 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // Load-use coinciding with a taken branch -> flush, no stall count
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        bus.EX_BranchTaken = 1'b1;
        settle();
        chk_ctrl("br", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        bus.EX_BranchTaken = 1'b0;
        set_nop();
        settle();
        chk("br_cnt", {24'd0, bus.StallCount}, 32'd1);
        chk_ctrl("br_after", 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset during a stall
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        settle();
        chk("rs_pre_stall", {31'd0, bus.PCWrite}, 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        chk_ctrl("rs_post", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rs_cnt", {24'd0, bus.StallCount}, 32'd0);
        drain();

        // Saturation: lw $2,0($2) held in ID stalls every other cycle
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        tick();
        repeat (2 * 254) tick();
        settle();
        chk("sat_254", {24'd0, bus.StallCount}, 32'd254);
        repeat (2) tick();
        settle();
        chk("sat_255", {24'd0, bus.StallCount}, 32'd255);
        repeat (4) tick();
        settle();
        chk("sat_hold", {24'd0, bus.StallCount}, 32'd255);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
